// File: rtl/seq_right_shift_unit.sv
// Multi-cycle SRL/SRA unit with valid/ready handshakes on both sides.
// Define SEQ_SHIFT_STEP4_EN to shift up to 4 bits per cycle instead of 1.
module seq_right_shift_unit #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] b,
  input  logic               arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_d;
  logic [WIDTH-1:0]   result_d;
  logic [SHAMT_W-1:0] count, count_d;
  logic               arith_q, arith_d;
  logic               fill;
  logic [SHAMT_W-1:0] step;
  logic [WIDTH-1:0]   shifted;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = !in_ready;

  // The held sign bit is reused each step, so SRA fill stays correct throughout.
  assign fill = arith_q & result[WIDTH-1];

`ifdef SEQ_SHIFT_STEP4_EN
  always_comb begin
    step    = (count >= SHAMT_W'(4)) ? SHAMT_W'(4) : count;
    shifted = result;
    case (step)
      SHAMT_W'(1): shifted = {{1{fill}}, result[WIDTH-1:1]};
      SHAMT_W'(2): shifted = {{2{fill}}, result[WIDTH-1:2]};
      SHAMT_W'(3): shifted = {{3{fill}}, result[WIDTH-1:3]};
      default:     shifted = {{4{fill}}, result[WIDTH-1:4]};
    endcase
  end
`else
  always_comb begin
    step    = SHAMT_W'(1);
    shifted = {fill, result[WIDTH-1:1]};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      result  <= '0;
      count   <= '0;
      arith_q <= 1'b0;
    end else begin
      state   <= state_d;
      result  <= result_d;
      count   <= count_d;
      arith_q <= arith_d;
    end
  end

  always_comb begin
    state_d  = state;
    result_d = result;
    count_d  = count;
    arith_d  = arith_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          result_d = a;
          count_d  = b;
          arith_d  = arith;
          state_d  = (b == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        result_d = shifted;
        count_d  = count - step;
        if (count == step) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_right_shift_unit.sv
// Directed testbench for seq_right_shift_unit; honours SEQ_SHIFT_STEP4_EN for latency expectations.
module tb_seq_right_shift_unit;

`ifdef SEQ_SHIFT_STEP4_EN
  localparam int STEPMAX = 4;
`else
  localparam int STEPMAX = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [5:0]  b;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  seq_right_shift_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .arith(arith), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input int amt);
    return (amt == 0) ? 0 : (amt + STEPMAX - 1) / STEPMAX;
  endfunction

  // Presents a request and leaves right after the accepting edge (+1).
  task automatic start_op(input logic [63:0] av, input logic [5:0] bv, input logic ar, input string tag);
    @(posedge clk); #1;
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    a = av; b = bv; arith = ar; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0; arith = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid, then checks latency/result.
  task automatic wait_done(input int amt, input logic [63:0] expres, input string tag);
    int lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat(amt)));
    check({tag, "_result"}, result, expres);
    check({tag, "_busy"}, {63'd0, busy}, 64'd1);
  endtask

  task automatic finish_op(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_idle"}, {61'd0, out_valid, in_ready, busy}, 64'b010);
  endtask

  task automatic run_op(input logic [63:0] av, input logic [5:0] bv, input logic ar,
                        input logic [63:0] expres, input string tag);
    start_op(av, bv, ar, tag);
    wait_done(int'(bv), expres, tag);
    finish_op(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; arith = 1'b0;
    #12;
    check("reset_flags", {61'd0, out_valid, in_ready, busy}, 64'b010);
    check("reset_result", result, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(64'h8000_0000_0000_0000, 6'd1,  1'b0, 64'h4000_0000_0000_0000, "srl1");
    run_op(64'h8000_0000_0000_0000, 6'd4,  1'b1, 64'hF800_0000_0000_0000, "sra4");
    run_op(64'h0000_0000_0000_1234, 6'd0,  1'b1, 64'h0000_0000_0000_1234, "b0");
    run_op(64'h8000_0000_0000_0000, 6'd63, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "sra63");
    run_op(64'h8000_0000_0000_0000, 6'd63, 1'b0, 64'h0000_0000_0000_0001, "srl63");
    run_op(64'hFEDC_BA98_7654_3210, 6'd8,  1'b1, 64'hFFFE_DCBA_9876_5432, "sra8");
    run_op(64'h0000_0000_0000_0F00, 6'd7,  1'b0, 64'h0000_0000_0000_001E, "srl7");
    run_op(64'h8000_0000_0000_0000, 6'd6,  1'b1, 64'hFE00_0000_0000_0000, "sra6");
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 6'd5,  1'b1, 64'h03FF_FFFF_FFFF_FFFF, "sra_pos");

    // Backpressure: hold DONE, attempt a new request which must be ignored.
    start_op(64'hA5A5_0000_0000_0000, 6'd3, 1'b1, "bp");
    wait_done(3, 64'hF4B4_A000_0000_0000, "bp");
    a = 64'hDEAD_BEEF_DEAD_BEEF; b = 6'd9; arith = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_result", result, 64'hF4B4_A000_0000_0000);
      check("bp_hold_flags", {61'd0, out_valid, in_ready, busy}, 64'b101);
    end
    in_valid = 1'b0;
    finish_op("bp");
    run_op(64'h0123_4567_89AB_CDEF, 6'd16, 1'b0, 64'h0000_0123_4567_89AB, "after_bp");

    // Asynchronous reset in the middle of a long shift.
    start_op(64'hFFFF_0000_FFFF_0000, 6'd40, 1'b1, "rst");
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_flags", {61'd0, out_valid, in_ready, busy}, 64'b010);
    check("rst_async_result", result, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(64'h0000_0000_0000_00FF, 6'd4, 1'b0, 64'h0000_0000_0000_000F, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
